// File: rtl/led_pwm_axi_ip.sv
// led_pwm_axi_ip: N-channel LED driver (off/on/blink/PWM) fed by two AXI-lite slave registers.
//   clk          : system clock, everything on its rising edge
//   resetn       : synchronous active-low reset
//   slv_reg_mode : [31] global enable, [2i+1:2i] channel i mode (00 off, 01 on, 10 blink, 11 PWM)
//   slv_reg_duty : [8i+PWM_W-1:8i] channel i PWM duty
//   led_out      : registered LED drive, bit i = channel i
module led_pwm_axi_ip #(
    parameter int N_LEDS    = 4,
    parameter int PWM_W     = 8,
    parameter int PRESCALE  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       slv_reg_mode,
    input  logic [31:0]       slv_reg_duty,
    output logic [N_LEDS-1:0] led_out
);
    localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int BD_W = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [PS_W-1:0]   presc_q, presc_d;
    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic [BD_W-1:0]   blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [N_LEDS-1:0] led_d;
    logic              tick, wrap, blink_end, en;
    // Fields beyond N_LEDS channels are deliberately ignored.
    logic              unused_ok;

    assign unused_ok = ^{slv_reg_mode, slv_reg_duty};
    assign en        = slv_reg_mode[31];

    always_comb begin
        tick      = presc_q == PS_W'(PRESCALE - 1);
        wrap      = tick && (pwm_q == {PWM_W{1'b1}});
        blink_end = wrap && (blink_q == BD_W'(BLINK_DIV - 1));
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_d     = tick ? pwm_q + 1'b1 : pwm_q;
        blink_d   = blink_end ? '0 : wrap ? blink_q + 1'b1 : blink_q;
        phase_d   = blink_end ? ~phase_q : phase_q;
        led_d     = '0;
        // Outputs use pre-edge counter values, so a mode change on a tick/wrap edge sees the old count.
        for (int i = 0; i < N_LEDS; i++) begin
            led_d[i] = slv_reg_mode[2*i+1] ? (slv_reg_mode[2*i] ? (pwm_q < slv_reg_duty[8*i +: PWM_W]) : phase_q)
                                           : slv_reg_mode[2*i];
        end
    end

    // Global enable low behaves like reset so re-enable restarts PWM and blink deterministically.
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            presc_q <= '0;
            pwm_q   <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            led_out <= '0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            led_out <= led_d;
        end
    end
endmodule

// File: tb/tb_led_pwm_axi_ip.sv
// tb_led_pwm_axi_ip: directed self-checking bench for led_pwm_axi_ip.
module tb_led_pwm_axi_ip;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] slv_reg_mode = '0;
    logic [31:0] slv_reg_duty = '0;
    logic [3:0]  led_out;
    int checks = 0;
    int errors = 0;

    led_pwm_axi_ip #(.N_LEDS(4), .PWM_W(8), .PRESCALE(2), .BLINK_DIV(2)) dut (
        .clk(clk), .resetn(resetn), .slv_reg_mode(slv_reg_mode),
        .slv_reg_duty(slv_reg_duty), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] mode, input logic [31:0] duty);
        slv_reg_mode = mode;
        slv_reg_duty = duty;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        slv_reg_mode = 32'h8000_0055;
        slv_reg_duty = '0;
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (led_out !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %b want 0000", i, led_out);
            end
        end
        resetn = 1'b1;
        step();
        checks++;
        if (led_out !== 4'b1111) begin
            errors++;
            $display("FAIL reset_release: got %b want 1111", led_out);
        end
    endtask

    task automatic test_static();
        do_reset(32'h8000_0000, 32'h8000_0000);
        slv_reg_mode = 32'h8000_0011;
        step();
        checks++;
        if (led_out !== 4'b0101) begin
            errors++;
            $display("FAIL static_on: got %b want 0101", led_out);
        end
        slv_reg_mode = 32'h8000_0000;
        step();
        checks++;
        if (led_out !== 4'b0000) begin
            errors++;
            $display("FAIL static_off: got %b want 0000", led_out);
        end
        slv_reg_mode = 32'h8000_00E4;
        step();
        checks++;
        if (led_out !== 4'b1010) begin
            errors++;
            $display("FAIL mixed_modes: got %b want 1010", led_out);
        end
        slv_reg_mode = 32'h8000_FF00;
        step();
        checks++;
        if (led_out !== 4'b0000) begin
            errors++;
            $display("FAIL unused_fields: got %b want 0000", led_out);
        end
    endtask

    task automatic pwm_period(input logic [7:0] duty, input int want_hi, input int want_first_low, input string name);
        int hi;
        int first_low;
        do_reset(32'h8000_0003, {24'h0, duty});
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            first_low = 0;
            for (int n = 1; n <= 512; n++) begin
                step();
                if (led_out[0] === 1'b1) hi++;
                else if (first_low == 0) first_low = n;
            end
            checks++;
            if (hi !== want_hi) begin
                errors++;
                $display("FAIL %s_high_count period %0d: got %0d want %0d", name, p, hi, want_hi);
            end
            checks++;
            if (first_low !== want_first_low) begin
                errors++;
                $display("FAIL %s_first_low period %0d: got %0d want %0d", name, p, first_low, want_first_low);
            end
        end
    endtask

    task automatic test_pwm();
        pwm_period(8'h40, 128, 129, "pwm40");
        pwm_period(8'h00, 0, 1, "pwm00");
        pwm_period(8'hFF, 510, 511, "pwmFF");
    endtask

    task automatic test_blink();
        int first_hi;
        int hi;
        do_reset(32'h8000_0008, '0);
        first_hi = 0;
        hi = 0;
        for (int n = 1; n <= 2049; n++) begin
            step();
            if (led_out[1] === 1'b1) begin
                hi++;
                if (first_hi == 0) first_hi = n;
            end
            if (n == 2049) begin
                checks++;
                if (led_out !== 4'b0000) begin
                    errors++;
                    $display("FAIL blink_second_low: got %b want 0000", led_out);
                end
            end
        end
        checks++;
        if (first_hi !== 1025) begin
            errors++;
            $display("FAIL blink_first_high: got %0d want 1025", first_hi);
        end
        checks++;
        if (hi !== 1024) begin
            errors++;
            $display("FAIL blink_high_len: got %0d want 1024", hi);
        end
    endtask

    task automatic test_enable();
        int hi;
        int first_low;
        do_reset(32'h8000_0003, 32'h0000_0040);
        for (int n = 0; n < 50; n++) step();
        checks++;
        if (led_out !== 4'b0001) begin
            errors++;
            $display("FAIL en_pre_high: got %b want 0001", led_out);
        end
        slv_reg_mode = 32'h0000_0003;
        step();
        checks++;
        if (led_out !== 4'b0000) begin
            errors++;
            $display("FAIL en_low: got %b want 0000", led_out);
        end
        for (int n = 0; n < 5; n++) step();
        checks++;
        if (led_out !== 4'b0000) begin
            errors++;
            $display("FAIL en_low_hold: got %b want 0000", led_out);
        end
        slv_reg_mode = 32'h8000_0003;
        hi = 0;
        first_low = 0;
        for (int n = 1; n <= 200; n++) begin
            step();
            if (led_out[0] === 1'b1 && first_low == 0) hi++;
            else if (first_low == 0) first_low = n;
        end
        checks++;
        if (hi !== 128 || first_low !== 129) begin
            errors++;
            $display("FAIL en_restart: got high %0d first_low %0d want 128/129", hi, first_low);
        end
    endtask

    task automatic test_reset_mid_blink();
        int first_hi;
        do_reset(32'h8000_0008, '0);
        for (int n = 0; n < 1030; n++) step();
        checks++;
        if (led_out !== 4'b0010) begin
            errors++;
            $display("FAIL midblink_high: got %b want 0010", led_out);
        end
        resetn = 1'b0;
        step();
        checks++;
        if (led_out !== 4'b0000) begin
            errors++;
            $display("FAIL midblink_reset: got %b want 0000", led_out);
        end
        resetn = 1'b1;
        first_hi = 0;
        for (int n = 1; n <= 1100; n++) begin
            step();
            if (led_out[1] === 1'b1 && first_hi == 0) first_hi = n;
        end
        checks++;
        if (first_hi !== 1025) begin
            errors++;
            $display("FAIL midblink_restart: got %0d want 1025", first_hi);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm();
        test_blink();
        test_enable();
        test_reset_mid_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
